// File: rtl/mux_n21_stream_pkg.sv
// mux_n21_stream_pkg: shared types and constants for the N-to-1 stream mux.
//   state_t        : packet FSM state (IDLE, LOCKED)
//   sel_w()        : select width for N channels, clog2(N) with a floor of 1
//   last_grant_rst : reset value of the round-robin pointer (N-1, so channel 0 wins first)
package mux_n21_stream_pkg;

    typedef enum logic {IDLE, LOCKED} state_t;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int last_grant_rst(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/mux_n21_rr_pick.sv
// mux_n21_rr_pick: combinational rotating-priority picker.
//   req     in  N : request per channel
//   last    in  M : previously granted channel; search starts at (last+1) mod N
//   gnt_idx out M : index of the winning channel (0 when none)
//   gnt_any out 1 : at least one request present
module mux_n21_rr_pick import mux_n21_stream_pkg::*; #(
    parameter int N = 8,
    localparam int M = sel_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [M-1:0] last,
    output logic [M-1:0] gnt_idx,
    output logic         gnt_any
);

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!gnt_any && req[(int'(last) + i) % N]) begin
                gnt_idx = M'((int'(last) + i) % N);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n21_stream.sv
// mux_n21_stream: N-to-1 valid/ready stream mux with packet locking and a registered output.
//   in_valid/in_data/in_last/in_ready : N input channels, channel k on in_data[k*W +: W]
//   sel                               : channel select, used only while not locked
//   out_valid/out_data/out_last/out_ch/out_ready : single registered output stream
//   sel_err                           : one-cycle pulse per cycle of out-of-range select in IDLE
//   pkt_cnt                           : completed packets forwarded, wraps
// Build option: define MUX_N21_STREAM_RR_EN to replace sel with round-robin among valid channels.
module mux_n21_stream import mux_n21_stream_pkg::*; #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int CW = 16,
    localparam int M = sel_w(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    input  logic [M-1:0]   sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [M-1:0]   out_ch,
    input  logic           out_ready,
    output logic           sel_err,
    output logic [CW-1:0]  pkt_cnt
);

    state_t       state_q, state_d;
    logic [M-1:0] lock_q, lock_d, g;
    logic         gv, accept, take, illegal, g_valid, g_last;
    logic [W-1:0] g_data;

    // Single output register: room exists when it is empty or being drained this cycle.
    assign accept = !out_valid || out_ready;

`ifdef MUX_N21_STREAM_RR_EN
    logic [M-1:0] last_grant, rr_idx;
    logic         rr_any;

    mux_n21_rr_pick #(.N(N)) u_pick (
        .req     (in_valid),
        .last    (last_grant),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    assign g       = (state_q == LOCKED) ? lock_q : rr_idx;
    assign gv      = (state_q == LOCKED) || rr_any;
    assign illegal = 1'b0;

    // Pointer moves only on the first beat of a packet so a locked packet cannot skew fairness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= M'(last_grant_rst(N));
        else if (take && state_q == IDLE)
            last_grant <= g;
    end
`else
    assign g       = (state_q == LOCKED) ? lock_q : sel;
    assign illegal = (state_q == IDLE) && (int'(sel) >= N);
    assign gv      = !illegal;
`endif

    // Decode by comparison so an out-of-range grant matches no channel.
    always_comb begin
        g_data   = '0;
        g_last   = 1'b0;
        g_valid  = 1'b0;
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            if (g == M'(k)) begin
                g_data      = in_data[k*W +: W];
                g_last      = in_last[k];
                g_valid     = in_valid[k];
                in_ready[k] = gv && accept;
            end
        end
    end

    assign take = gv && accept && g_valid;

    always_comb begin
        state_d = take ? (g_last ? IDLE : LOCKED) : state_q;
        lock_d  = (take && !g_last) ? g : lock_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            sel_err   <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= g_data;
                out_last  <= g_last;
                out_ch    <= g;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready && out_last)
                pkt_cnt <= pkt_cnt + CW'(1);
            sel_err <= illegal;
        end
    end

endmodule

// File: tb/tb_mux_n21_stream.sv
// tb_mux_n21_stream: directed scoreboard bench for mux_n21_stream (N=6, W=8, CW=4).
module tb_mux_n21_stream;

    localparam int N  = 6;
    localparam int W  = 8;
    localparam int CW = 4;
    localparam int M  = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid, in_last, in_ready, bg;
    logic [N*W-1:0] in_data;
    logic [M-1:0]   sel, out_ch;
    logic           out_valid, out_last, out_ready, sel_err, sb_on;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  pkt_cnt;

    int tests = 0;
    int fails = 0;
    int cnt   = 0;
    int w;
    logic [11:0] q[$];

    always #5 clk = ~clk;

    mux_n21_stream #(.N(N), .W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .sel(sel), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ch(out_ch), .out_ready(out_ready), .sel_err(sel_err),
        .pkt_cnt(pkt_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every output handshake must match the oldest accepted input beat.
    always @(negedge clk) begin
        #2;
        if (sb_on && rst_n && out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $error("FAIL sb_extra: got %0h expected nothing", {out_ch, out_last, out_data});
            end else begin
                assert ({out_ch, out_last, out_data} === q[0]) else begin
                    fails++;
                    $error("FAIL sb_beat: got %0h expected %0h", {out_ch, out_last, out_data}, q[0]);
                end
                if (out_last) cnt++;
                void'(q.pop_front());
            end
        end
    end

    // Drive one beat on channel ch, wait for its handshake, then verify one-cycle latency.
    task automatic send(input int ch, input logic [7:0] d, input logic l, output int waits);
        int t = 0;
        in_valid = bg;
        in_valid[ch] = 1'b1;
        in_data[ch*W +: W] = d;
        in_last[ch] = l;
        #1;
        while (!in_ready[ch] && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        waits = t;
        chk("ready_timeout", 32'(t < 50), 32'd1);
        chk("ready_onehot", 32'(in_ready), 32'(6'd1 << ch));
        q.push_back({M'(ch), l, d});
        @(negedge clk);
        #1;
        chk("latency", 32'({out_valid, out_ch, out_last, out_data}), 32'({1'b1, M'(ch), l, d}));
        in_valid = bg;
        in_last = '0;
    endtask

    task automatic drain;
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 50) begin
            @(negedge clk);
            #3;
            t++;
        end
        chk("drain_timeout", 32'(t < 50), 32'd1);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        q.delete();
        cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #3;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; in_data = '0; in_last = '0; sel = '0;
        out_ready = 1'b1; bg = '0; sb_on = 1'b1;
        #12;
        chk("rst_out", 32'({out_valid, out_data, out_last, out_ch, sel_err, pkt_cnt}), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
`ifdef MUX_N21_STREAM_RR_EN
        begin
            int seq[6] = '{0, 2, 5, 0, 2, 5};
            sb_on = 1'b0;
            sel = 3'd7;
            in_valid = 6'b100101;
            in_last = '1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                #1;
                chk("rr_ch", 32'({out_valid, out_ch}), 32'({1'b1, M'(seq[i])}));
                chk("rr_selerr", 32'(sel_err), 32'd0);
            end
            in_valid = '0;
        end
`else
        sel = 3'd3;
        send(3, 8'hA1, 1'b0, w); chk("basic_w1", w, 0);
        send(3, 8'hA2, 1'b0, w); chk("basic_w2", w, 0);
        send(3, 8'hA3, 1'b1, w); chk("basic_w3", w, 0);
        drain;
        chk("basic_cnt", 32'(pkt_cnt), 32'd1);

        bg = 6'b100000;
        send(3, 8'hB1, 1'b0, w);
        sel = 3'd5;
        send(3, 8'hB2, 1'b0, w);
        send(3, 8'hB3, 1'b0, w);
        send(3, 8'hB4, 1'b1, w);
        send(5, 8'hC1, 1'b1, w);
        bg = '0;
        in_valid = '0;
        drain;
        chk("lock_cnt", 32'(pkt_cnt), 32'd3);

        sel = 3'd2;
        send(2, 8'hD1, 1'b0, w);
        out_ready = 1'b0;
        in_valid[2] = 1'b1;
        in_data[2*W +: W] = 8'hD2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'({out_valid, out_last, out_data}), 32'({1'b1, 1'b0, 8'hD1}));
        end
        out_ready = 1'b1;
        send(2, 8'hD2, 1'b0, w); chk("bp_w2", w, 0);
        send(2, 8'hD3, 1'b1, w); chk("bp_w3", w, 0);
        drain;
        chk("bp_cnt", 32'(pkt_cnt), 32'd4);
        chk("bp_model_cnt", 32'(pkt_cnt), 32'(CW'(cnt)));

        @(negedge clk);
        sel = 3'd7;
        in_valid = '1;
        in_last = '1;
        #1;
        chk("ill_ready0", 32'(in_ready), 32'd0);
        chk("ill_err0", 32'(sel_err), 32'd0);
        @(negedge clk);
        #1;
        chk("ill_ready1", 32'(in_ready), 32'd0);
        chk("ill_err1", 32'({sel_err, out_valid}), 32'b10);
        @(negedge clk);
        sel = 3'd1;
        in_valid = '0;
        in_last = '0;
        #1;
        chk("ill_err2", 32'({sel_err, out_valid}), 32'b10);
        @(negedge clk);
        #1;
        chk("ill_err3", 32'({sel_err, out_valid}), 32'b00);

        out_ready = 1'b0;
        send(1, 8'hE1, 1'b0, w);
        #1;
        rst_n = 1'b0;
        q.delete();
        cnt = 0;
        #1;
        chk("midrst_out", 32'({out_valid, out_data, out_last, out_ch, sel_err, pkt_cnt}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sel = 3'd4;
        out_ready = 1'b1;
        send(4, 8'hF1, 1'b1, w);
        drain;
        chk("midrst_cnt", 32'(pkt_cnt), 32'd1);

        do_reset;
        sel = 3'd0;
        for (int i = 0; i < 17; i++) send(0, 8'(8'h10 + i), 1'b1, w);
        drain;
        chk("wrap_cnt", 32'(pkt_cnt), 32'd1);
        chk("wrap_model", 32'(pkt_cnt), 32'(CW'(cnt)));
        chk("sb_empty", 32'(q.size()), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
